pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RISC-V core.
- Combines four inputs and drives the per-stage write-enable, flush and bubble controls:
  - load-use hazard flag from the hazard detector in ID;
  - branch/jump redirect from EX;
  - data-memory wait handshake from MEM;
  - terminate request from WB.
- Holds a small FSM for multi-cycle freezes, branch squash and halt, plus saturating performance counters.

Parameters:
- BR_PENALTY, 1: cycles IF/ID is squashed after a redirect; legal range 1..7.
- CNT_W, 16: width of each performance counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RSTn  input  1  asynchronous, active-low reset.
- data_hazard_check  input  1  load-use hazard between ID and EX.
- ex_redirect  input  1  taken branch, JAL or JALR resolved in EX this cycle.
- dmem_req  input  1  MEM stage holds a load or store.
- dmem_ready  input  1  data memory completes the access this cycle.
- halt_req  input  1  terminating instruction in WB.
- pc_write  output  1  PC register update enable.
- ifid_write  output  1  IF/ID latch enable.
- ifid_flush  output  1  IF/ID loaded with NOP; dominates ifid_write.
- idex_bubble  output  1  ID/EX loaded with NOP.
- exmem_write  output  1  EX/MEM and ID/EX latch enable.
- memwb_write  output  1  MEM/WB latch enable.
- halted  output  1  core halted (sticky).
- stall_cnt  output  CNT_W  cycles with pc_write=0 while not halted.
- flush_cnt  output  CNT_W  number of accepted redirects.

Behaviour:
- States: RUN, MEM_WAIT, SQUASH, HALT. A 3-bit squash counter sq_cnt is used in SQUASH.
- Outputs are combinational from state and inputs. Default: pc_write, ifid_write, exmem_write and memwb_write = 1; ifid_flush, idex_bubble and halted = 0.
- Reset (RSTn=0, asynchronous):
  - state=RUN, sq_cnt=0, both counters=0.
  - While RSTn=0, every output is 0, including all write enables.
- RUN. Conditions are evaluated in priority order; the first match applies:
  1. halt_req=1: all write enables 0; next state HALT.
  2. dmem_req=1 and dmem_ready=0: all write enables 0 (whole pipe frozen); next state MEM_WAIT.
  3. ex_redirect=1:
     - ifid_flush=1 and idex_bubble=1; pc_write=1 (the target is loaded).
     - flush_cnt increments.
     - If BR_PENALTY>1: next state SQUASH with sq_cnt=BR_PENALTY-1. Otherwise stay in RUN.
  4. data_hazard_check=1: pc_write=0, ifid_write=0, idex_bubble=1; stay in RUN. This is a one-cycle bubble; the hazard clears once the load reaches MEM.
  5. Otherwise: default outputs.
- MEM_WAIT:
  - All write enables 0. ex_redirect and data_hazard_check are ignored; their sources are frozen.
  - When dmem_ready=1, that cycle outputs the defaults and the next state is RUN. Any redirect or hazard still present is serviced in the next RUN cycle.
  - halt_req=1 takes priority: go to HALT.
- SQUASH:
  - ifid_flush=1, idex_bubble=1, pc_write=1.
  - sq_cnt decrements each cycle; when sq_cnt==1, next state is RUN.
  - If dmem_req=1 and dmem_ready=0: freeze all enables. sq_cnt holds and the state stays in SQUASH.
  - A new ex_redirect cannot occur because EX holds a bubble; the input is ignored.
- HALT:
  - All write enables 0, halted=1.
  - Exit only through reset.
- Counters:
  - stall_cnt increments every cycle in which RSTn=1, state≠HALT and pc_write=0.
  - flush_cnt increments once per redirect accepted in RUN.
  - Both saturate at 2^CNT_W-1; no wrap-around.
- Reset asserted mid-freeze or mid-squash returns the FSM to RUN immediately; there is no residual flush.

Test Plan:
- Reset with all inputs 0, then release: outputs stay 0 while RSTn=0. The first cycle after release has pc_write=1, ifid_write=1, exmem_write=1, memwb_write=1, and stall_cnt=0.
- data_hazard_check=1 for 1 cycle in RUN: that cycle pc_write=0, ifid_write=0, idex_bubble=1; the next cycle returns to defaults; stall_cnt=1.
- dmem_req=1 and dmem_ready=0 for 3 cycles, then dmem_ready=1: all enables 0 for 3 cycles, then defaults; stall_cnt=3. A data_hazard_check raised during the wait gives no bubble until RUN.
- BR_PENALTY=3, ex_redirect pulse: ifid_flush=1 and idex_bubble=1 for exactly 3 cycles, pc_write=1 throughout; flush_cnt=1. Add a 2-cycle memory wait inside SQUASH: flush spans 5 cycles, with the enables frozen for 2 of them.
- halt_req together with ex_redirect and a memory wait: HALT wins, halted=1 and all enables 0 indefinitely. stall_cnt stops counting. Pulsing RSTn low returns to RUN with counters at 0.
- CNT_W=4, hold data_hazard_check=1 for 20 cycles: stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Stall-controller bundle: hazard/redirect/memory/halt inputs and
// per-stage enable, flush, bubble and counter outputs.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             data_hazard_check;
    logic             ex_redirect;
    logic             dmem_req;
    logic             dmem_ready;
    logic             halt_req;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_write;
    logic             memwb_write;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output data_hazard_check,
        output ex_redirect,
        output dmem_req,
        output dmem_ready,
        output halt_req,
        input  pc_write,
        input  ifid_write,
        input  ifid_flush,
        input  idex_bubble,
        input  exmem_write,
        input  memwb_write,
        input  halted,
        input  stall_cnt,
        input  flush_cnt
    );

    modport slave (
        input  data_hazard_check,
        input  ex_redirect,
        input  dmem_req,
        input  dmem_ready,
        input  halt_req,
        output pc_write,
        output ifid_write,
        output ifid_flush,
        output idex_bubble,
        output exmem_write,
        output memwb_write,
        output halted,
        output stall_cnt,
        output flush_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush/halt sequencer for the 5-stage pipeline with
// saturating stall and redirect counters.
module pipe_stall_ctrl #(
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    pipe_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        SQUASH,
        HALT
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [2:0]       SQ_INIT = 3'(BR_PENALTY - 1);

    state_e           state_q, state_d;
    logic [2:0]       sq_cnt_q, sq_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic pc_w;
    logic ifid_w;
    logic ifid_fl;
    logic bub;
    logic exmem_w;
    logic memwb_w;
    logic hlt;
    logic freeze;
    logic redir_acc;
    logic mem_stall;

    assign mem_stall = bus.dmem_req & ~bus.dmem_ready;

    always_comb begin
        pc_w      = 1'b1;
        ifid_w    = 1'b1;
        ifid_fl   = 1'b0;
        bub       = 1'b0;
        exmem_w   = 1'b1;
        memwb_w   = 1'b1;
        hlt       = 1'b0;
        freeze    = 1'b0;
        redir_acc = 1'b0;
        state_d   = state_q;
        sq_cnt_d  = sq_cnt_q;

        unique case (state_q)
            RUN: begin
                if (bus.halt_req) begin
                    freeze  = 1'b1;
                    state_d = HALT;
                end else if (mem_stall) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                end else if (bus.ex_redirect) begin
                    ifid_fl   = 1'b1;
                    bub       = 1'b1;
                    redir_acc = 1'b1;
                    if (BR_PENALTY > 1) begin
                        state_d  = SQUASH;
                        sq_cnt_d = SQ_INIT;
                    end
                end else if (bus.data_hazard_check) begin
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    bub    = 1'b1;
                end
            end

            // Redirect/hazard sources are frozen here; they are
            // re-examined in the first RUN cycle after the wait.
            MEM_WAIT: begin
                if (bus.halt_req) begin
                    freeze  = 1'b1;
                    state_d = HALT;
                end else if (bus.dmem_ready) begin
                    state_d = RUN;
                end else begin
                    freeze = 1'b1;
                end
            end

            SQUASH: begin
                ifid_fl = 1'b1;
                bub     = 1'b1;
                if (bus.halt_req) begin
                    freeze  = 1'b1;
                    state_d = HALT;
                end else if (mem_stall) begin
                    freeze = 1'b1;
                end else begin
                    sq_cnt_d = sq_cnt_q - 3'd1;
                    if (sq_cnt_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
            end

            HALT: begin
                freeze = 1'b1;
                hlt    = 1'b1;
            end

            default: begin
                state_d = RUN;
            end
        endcase

        if (freeze) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            exmem_w = 1'b0;
            memwb_w = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != HALT && !pc_w && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redir_acc && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= RUN;
            sq_cnt_q    <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sq_cnt_q    <= sq_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Every control is forced low while reset is held.
    assign bus.pc_write    = RSTn & pc_w;
    assign bus.ifid_write  = RSTn & ifid_w;
    assign bus.ifid_flush  = RSTn & ifid_fl;
    assign bus.idex_bubble = RSTn & bub;
    assign bus.exmem_write = RSTn & exmem_w;
    assign bus.memwb_write = RSTn & memwb_w;
    assign bus.halted      = RSTn & hlt;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed vector bench for pipe_stall_ctrl: a BR_PENALTY=3 instance
// for the main table and a BR_PENALTY=1, CNT_W=4 instance for saturation.
module tb_pipe_stall_ctrl;

    typedef struct {
        logic [4:0] in;
        logic [6:0] exp;
        int         stl;
        int         fls;
    } vec_t;

    localparam logic [6:0] D   = 7'b1100110;
    localparam logic [6:0] HZ  = 7'b0001110;
    localparam logic [6:0] FRZ = 7'b0000000;
    localparam logic [6:0] SQ  = 7'b1111110;
    localparam logic [6:0] SQF = 7'b0011000;
    localparam logic [6:0] HLT = 7'b0000001;

    logic CLK;
    logic RSTn;
    int   total;
    int   bad;
    vec_t tv[27];

    pipe_stall_ctrl_if #(.CNT_W(16)) a_if ();
    pipe_stall_ctrl_if #(.CNT_W(4))  b_if ();

    pipe_stall_ctrl #(.BR_PENALTY(3), .CNT_W(16)) dut_a (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (a_if)
    );

    pipe_stall_ctrl #(.BR_PENALTY(1), .CNT_W(4)) dut_b (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (b_if)
    );

    wire [6:0] a_out = {a_if.pc_write, a_if.ifid_write, a_if.ifid_flush,
                        a_if.idex_bubble, a_if.exmem_write,
                        a_if.memwb_write, a_if.halted};
    wire [6:0] b_out = {b_if.pc_write, b_if.ifid_write, b_if.ifid_flush,
                        b_if.idex_bubble, b_if.exmem_write,
                        b_if.memwb_write, b_if.halted};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // in = {hazard, redirect, dmem_req, dmem_ready, halt_req}
    task automatic drive_a(input logic [4:0] v);
        a_if.data_hazard_check = v[4];
        a_if.ex_redirect       = v[3];
        a_if.dmem_req          = v[2];
        a_if.dmem_ready        = v[1];
        a_if.halt_req          = v[0];
    endtask

    task automatic drive_b(input logic [4:0] v);
        b_if.data_hazard_check = v[4];
        b_if.ex_redirect       = v[3];
        b_if.dmem_req          = v[2];
        b_if.dmem_ready        = v[1];
        b_if.halt_req          = v[0];
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic set_tv(input int i, input logic [4:0] in,
                          input logic [6:0] exp, input int stl,
                          input int fls);
        tv[i].in  = in;
        tv[i].exp = exp;
        tv[i].stl = stl;
        tv[i].fls = fls;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        set_tv(0,  5'b00000, D,   0, 0);
        set_tv(1,  5'b10000, HZ,  0, 0);
        set_tv(2,  5'b00000, D,   1, 0);
        set_tv(3,  5'b00100, FRZ, 1, 0);
        set_tv(4,  5'b10100, FRZ, 2, 0);
        set_tv(5,  5'b00100, FRZ, 3, 0);
        set_tv(6,  5'b10110, D,   4, 0);
        set_tv(7,  5'b10000, HZ,  4, 0);
        set_tv(8,  5'b00000, D,   5, 0);
        set_tv(9,  5'b01000, SQ,  5, 0);
        set_tv(10, 5'b00000, SQ,  5, 1);
        set_tv(11, 5'b00000, SQ,  5, 1);
        set_tv(12, 5'b00000, D,   5, 1);
        set_tv(13, 5'b01000, SQ,  5, 1);
        set_tv(14, 5'b00100, SQF, 5, 2);
        set_tv(15, 5'b00100, SQF, 6, 2);
        set_tv(16, 5'b00000, SQ,  7, 2);
        set_tv(17, 5'b01000, SQ,  7, 2);
        set_tv(18, 5'b00000, D,   7, 2);
        set_tv(19, 5'b11000, SQ,  7, 2);
        set_tv(20, 5'b00000, SQ,  7, 3);
        set_tv(21, 5'b00000, SQ,  7, 3);
        set_tv(22, 5'b00000, D,   7, 3);
        set_tv(23, 5'b01101, FRZ, 7, 3);
        set_tv(24, 5'b00000, HLT, 8, 3);
        set_tv(25, 5'b11000, HLT, 8, 3);
        set_tv(26, 5'b00100, HLT, 8, 3);

        RSTn = 1'b0;
        drive_a(5'b00000);
        drive_b(5'b00000);
        repeat (2) @(negedge CLK);
        #2;
        chk("rst_outs_a", int'(a_out), 0);
        chk("rst_outs_b", int'(b_out), 0);
        chk("rst_stall", int'(a_if.stall_cnt), 0);
        drive_a(5'b11001);
        @(negedge CLK);
        #2;
        chk("rst_outs_busy_in", int'(a_out), 0);
        drive_a(5'b00000);

        @(negedge CLK);
        RSTn = 1'b1;

        for (int i = 0; i < 27; i++) begin
            @(negedge CLK);
            drive_a(tv[i].in);
            #2;
            chk($sformatf("vec%0d_outs", i), int'(a_out), int'(tv[i].exp));
            chk($sformatf("vec%0d_stall", i), int'(a_if.stall_cnt),
                tv[i].stl);
            chk($sformatf("vec%0d_flush", i), int'(a_if.flush_cnt),
                tv[i].fls);
        end

        // Reset out of HALT
        @(negedge CLK);
        drive_a(5'b00000);
        RSTn = 1'b0;
        #2;
        chk("halt_rst_outs", int'(a_out), 0);
        chk("halt_rst_stall", int'(a_if.stall_cnt), 0);
        chk("halt_rst_flush", int'(a_if.flush_cnt), 0);
        @(negedge CLK);
        RSTn = 1'b1;
        #2;
        chk("halt_rel_outs", int'(a_out), int'(D));

        // Reset in the middle of a squash leaves no residual flush
        @(negedge CLK);
        drive_a(5'b01000);
        #2;
        chk("sq_start_outs", int'(a_out), int'(SQ));
        @(negedge CLK);
        drive_a(5'b00000);
        #2;
        chk("sq_mid_outs", int'(a_out), int'(SQ));
        @(negedge CLK);
        RSTn = 1'b0;
        #2;
        chk("sq_rst_outs", int'(a_out), 0);
        @(negedge CLK);
        RSTn = 1'b1;
        #2;
        chk("sq_rel_outs", int'(a_out), int'(D));
        chk("sq_rel_flush", int'(a_if.flush_cnt), 0);

        // BR_PENALTY=1: single flush cycle, stays in RUN
        @(negedge CLK);
        drive_b(5'b01000);
        #2;
        chk("b_redir_outs", int'(b_out), int'(SQ));
        @(negedge CLK);
        drive_b(5'b00000);
        #2;
        chk("b_after_redir_outs", int'(b_out), int'(D));
        chk("b_flush_cnt", int'(b_if.flush_cnt), 1);

        // CNT_W=4 saturation
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            drive_b(5'b10000);
            #2;
            if (i == 10) begin
                chk("b_stall_mid", int'(b_if.stall_cnt), 10);
            end
        end
        @(negedge CLK);
        drive_b(5'b00000);
        #2;
        chk("b_stall_sat", int'(b_if.stall_cnt), 15);
        chk("b_outs_idle", int'(b_out), int'(D));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
